// File: rtl/instr_issue_unit.sv
// instr_issue_unit: loadable program store that issues one 12-bit instruction
// per valid/ready handshake, in slot order, until a HALT word or the last slot.
module instr_issue_unit #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [11:0]   wr_data,
  input  logic          start,
  input  logic          abort,
  output logic [11:0]   instr_out,
  output logic          instr_valid,
  input  logic          instr_ready,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] pc,
  output logic [AW:0]   issued_count
);

  typedef enum logic {IDLE, ISSUE} state_e;

  localparam logic [2:0]    OP_HALT   = 3'b000;
  localparam logic [AW-1:0] LAST_SLOT = AW'(DEPTH - 1);

  state_e        state_q, state_d;
  logic [11:0]   instr_q, instr_d;
  logic          valid_q, valid_d;
  logic          done_q, done_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [AW:0]   cnt_q, cnt_d;

  logic [11:0]   mem_q [DEPTH];
  logic          mem_we;
  logic [AW-1:0] pc_next;
  logic [11:0]   next_word;
  logic [11:0]   slot0_word;
  logic          handshake;

  // Next-state, store write enable and issue control.
  always_comb begin
    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
    state_d    = state_q;
    instr_d    = instr_q;
    valid_d    = valid_q;
    done_d     = 1'b0;
    pc_d       = pc_q;
    cnt_d      = cnt_q;
    mem_we     = 1'b0;
    pc_next    = pc_q + 1'b1;
    next_word  = mem_q[pc_next];
    // A slot-0 write in the same cycle as start is forwarded to the start decision.
    slot0_word = (wr_en && wr_addr == '0) ? wr_data : mem_q[0];
    handshake  = valid_q && instr_ready;

    if (abort) begin
      // Abort wins over start, writes and a coincident handshake; count holds.
      state_d = IDLE;
      valid_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          mem_we = wr_en;
          if (start) begin
            cnt_d = '0;
            if (slot0_word[11:9] == OP_HALT) begin
              done_d = 1'b1;
            end else begin
              state_d = ISSUE;
              pc_d    = '0;
              instr_d = slot0_word;
              valid_d = 1'b1;
            end
          end
        end
        ISSUE: begin
          if (handshake) begin
            cnt_d = cnt_q + 1'b1;
            if (pc_q == LAST_SLOT || next_word[11:9] == OP_HALT) begin
              state_d = IDLE;
              valid_d = 1'b0;
              done_d  = 1'b1;
            end else begin
              pc_d    = pc_next;
              instr_d = next_word;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (rst) begin
      state_q <= IDLE;
      instr_q <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      pc_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  // Program store: synchronous write, cleared to HALT on reset.
  always_ff @(posedge clk) begin
    // NOTE: the store is reset on purpose, so a start after reset sees an empty program.
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (mem_we) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign instr_out    = instr_q;
  assign instr_valid  = valid_q;
  assign busy         = (state_q == ISSUE);
  assign done         = done_q;
  assign pc           = pc_q;
  assign issued_count = cnt_q;

endmodule

// File: tb/tb_instr_issue_unit.sv
// Directed bench for instr_issue_unit: full run, backpressure, empty program,
// slot-0 bypass, last-slot boundary, abort, reset mid-run, ignored inputs.
module tb_instr_issue_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic [3:0]  wr_addr = '0;
  logic [11:0] wr_data = '0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        instr_ready = 1'b0;
  logic [11:0] instr_out;
  logic        instr_valid;
  logic        busy;
  logic        done;
  logic [3:0]  pc;
  logic [4:0]  issued_count;

  int checks = 0;
  int errors = 0;

  logic [11:0] prog [8] = '{12'h281, 12'h4C1, 12'h701, 12'h901,
                            12'hBEE, 12'hDEE, 12'hE88, 12'h000};

  instr_issue_unit #(.DEPTH(16), .AW(4)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .abort(abort), .instr_out(instr_out), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .busy(busy), .done(done), .pc(pc),
    .issued_count(issued_count)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle before sampling outputs.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_prog();
    for (int i = 0; i < 8; i++) begin
      wr_en = 1'b1; wr_addr = 4'(i); wr_data = prog[i];
      step();
    end
    wr_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if ({instr_out, instr_valid, busy, done, pc, issued_count} !== 24'h0) begin
      errors++;
      $display("FAIL reset_outputs: out=%h v=%b busy=%b done=%b pc=%0d cnt=%0d required all 0",
               instr_out, instr_valid, busy, done, pc, issued_count);
    end
  endtask

  task automatic test_full_run();
    load_prog();
    instr_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      checks++;
      if ({instr_valid, busy, pc, instr_out} !== {1'b1, 1'b1, 4'(i), prog[i]}) begin
        errors++;
        $display("FAIL run_word%0d: v=%b busy=%b pc=%0d out=%h required v=1 busy=1 pc=%0d out=%h",
                 i, instr_valid, busy, pc, instr_out, i, prog[i]);
      end
      step();
    end
    checks++;
    if ({instr_valid, busy, done, pc, issued_count} !== {1'b0, 1'b0, 1'b1, 4'd6, 5'd7}) begin
      errors++;
      $display("FAIL run_done: v=%b busy=%b done=%b pc=%0d cnt=%0d required 0 0 1 6 7",
               instr_valid, busy, done, pc, issued_count);
    end
    step();
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL run_done_pulse: done=%b required 0", done);
    end
  endtask

  task automatic test_backpressure();
    automatic logic pat [3] = '{1'b1, 1'b0, 1'b0};
    automatic int idx = 0;
    automatic int c = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    while (idx < 7 && c < 40) begin
      instr_ready = pat[c % 3];
      checks++;
      if ({instr_valid, pc, instr_out} !== {1'b1, 4'(idx), prog[idx]}) begin
        errors++;
        $display("FAIL bp_cycle%0d: v=%b pc=%0d out=%h required v=1 pc=%0d out=%h",
                 c, instr_valid, pc, instr_out, idx, prog[idx]);
      end
      step();
      if (instr_ready) idx++;
      c++;
    end
    checks++;
    if (idx != 7) begin
      errors++;
      $display("FAIL bp_timeout: issued %0d words required 7", idx);
    end
    checks++;
    if ({instr_valid, done, issued_count} !== {1'b0, 1'b1, 5'd7}) begin
      errors++;
      $display("FAIL bp_done: v=%b done=%b cnt=%0d required 0 1 7",
               instr_valid, done, issued_count);
    end
    instr_ready = 1'b1;
  endtask

  task automatic test_empty_bypass();
    test_reset();
    start = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if ({done, instr_valid, busy} !== 3'b100) begin
      errors++;
      $display("FAIL empty_done: done=%b v=%b busy=%b required 1 0 0", done, instr_valid, busy);
    end
    step();
    checks++;
    if ({done, instr_valid} !== 2'b00) begin
      errors++;
      $display("FAIL empty_after: done=%b v=%b required 0 0", done, instr_valid);
    end
    wr_en = 1'b1; wr_addr = 4'd0; wr_data = 12'h281; start = 1'b1; instr_ready = 1'b1;
    step();
    wr_en = 1'b0; start = 1'b0;
    checks++;
    if ({instr_valid, instr_out} !== {1'b1, 12'h281}) begin
      errors++;
      $display("FAIL bypass_issue: v=%b out=%h required v=1 out=281", instr_valid, instr_out);
    end
    step();
    checks++;
    if ({done, instr_valid, issued_count} !== {1'b1, 1'b0, 5'd1}) begin
      errors++;
      $display("FAIL bypass_done: done=%b v=%b cnt=%0d required 1 0 1",
               done, instr_valid, issued_count);
    end
  endtask

  task automatic test_full_store();
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1; wr_addr = 4'(i); wr_data = 12'h281;
      step();
    end
    wr_en = 1'b0;
    instr_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      checks++;
      if ({instr_valid, pc, instr_out} !== {1'b1, 4'(i), 12'h281}) begin
        errors++;
        $display("FAIL full_slot%0d: v=%b pc=%0d out=%h required v=1 pc=%0d out=281",
                 i, instr_valid, pc, instr_out, i);
      end
      step();
    end
    checks++;
    if ({done, instr_valid, pc, issued_count} !== {1'b1, 1'b0, 4'd15, 5'h10}) begin
      errors++;
      $display("FAIL full_done: done=%b v=%b pc=%0d cnt=%h required 1 0 15 10",
               done, instr_valid, pc, issued_count);
    end
  endtask

  task automatic test_abort();
    load_prog();
    instr_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    checks++;
    if ({pc, instr_out} !== {4'd2, prog[2]}) begin
      errors++;
      $display("FAIL abort_setup: pc=%0d out=%h required pc=2 out=%h", pc, instr_out, prog[2]);
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    checks++;
    if ({instr_valid, busy, done, issued_count} !== {1'b0, 1'b0, 1'b0, 5'd2}) begin
      errors++;
      $display("FAIL abort_stop: v=%b busy=%b done=%b cnt=%0d required 0 0 0 2",
               instr_valid, busy, done, issued_count);
    end
    step();
    checks++;
    if ({done, instr_valid} !== 2'b00) begin
      errors++;
      $display("FAIL abort_no_done: done=%b v=%b required 0 0", done, instr_valid);
    end
  endtask

  task automatic test_reset_mid_run();
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if ({instr_out, instr_valid, busy, done, pc, issued_count} !== 24'h0) begin
      errors++;
      $display("FAIL rst_mid_outputs: out=%h v=%b busy=%b done=%b pc=%0d cnt=%0d required all 0",
               instr_out, instr_valid, busy, done, pc, issued_count);
    end
    start = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if ({done, instr_valid} !== 2'b10) begin
      errors++;
      $display("FAIL rst_store_cleared: done=%b v=%b required 1 0", done, instr_valid);
    end
  endtask

  task automatic test_ignored_inputs();
    load_prog();
    instr_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    // pc=1 on the bus: a write to slot 3 with a HALT word and a restart request.
    wr_en = 1'b1; wr_addr = 4'd3; wr_data = 12'h123; start = 1'b1;
    step();
    wr_en = 1'b0; start = 1'b0;
    for (int i = 2; i < 7; i++) begin
      checks++;
      if ({instr_valid, pc, instr_out} !== {1'b1, 4'(i), prog[i]}) begin
        errors++;
        $display("FAIL busy_ignore_word%0d: v=%b pc=%0d out=%h required v=1 pc=%0d out=%h",
                 i, instr_valid, pc, instr_out, i, prog[i]);
      end
      step();
    end
    checks++;
    if ({done, issued_count} !== {1'b1, 5'd7}) begin
      errors++;
      $display("FAIL busy_ignore_done: done=%b cnt=%0d required 1 7", done, issued_count);
    end
  endtask

  initial begin
    test_reset();
    test_full_run();
    test_backpressure();
    test_empty_bypass();
    test_full_store();
    test_abort();
    test_reset_mid_run();
    test_ignored_inputs();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_issue_unit.md
# instr_issue_unit

Program-driven instruction sequencer that feeds the CPU's 12-bit instruction input. It holds a small loadable program store and issues one instruction per accepted handshake, in address order, until it reaches an end marker or the last slot. It replaces hand-timed instruction stimulus with a self-timed source, and sits directly in front of the CPU instruction port.

## Interface
Parameters:
- DEPTH, 16, number of 12-bit program slots (power of two).
- AW, 4, address width, log2(DEPTH).

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- wr_en  in  1  program-store write strobe; honoured only when busy=0.
- wr_addr  in  AW  program slot to write.
- wr_data  in  12  instruction word: [11:9] opcode, [8:6] rd, [5:3] rs1, [2:0] rs2.
- start  in  1  begin issuing from slot 0; honoured only when busy=0.
- abort  in  1  stop issuing immediately, with no done pulse.
- instr_out  out  12  instruction presented to the CPU.
- instr_valid  out  1  instr_out holds a valid instruction.
- instr_ready  in  1  CPU accepts instr_out this cycle.
- busy  out  1  high in the ISSUE state.
- done  out  1  one-cycle pulse when a program completes normally.
- pc  out  AW  slot index of the instruction currently on instr_out.
- issued_count  out  AW+1  handshakes completed since the last start.

## Operation
- Opcode map: 000 HALT/end marker (never issued); 001 ADD; 010 SUB; 011 MUL; 100 IMUL; 101 FADD; 110 FMUL; 111 CMP. The unit does not decode non-zero opcodes and passes them through unchanged.
- Program store is a DEPTH x 12 register array with a synchronous write.
- States: IDLE and ISSUE.
- IDLE:
  - wr_en writes mem[wr_addr].
  - On start:
    - If the slot-0 word has opcode 000, stay in IDLE and pulse done. The slot-0 word is wr_data when wr_en=1 and wr_addr=0 in the same cycle (bypass); otherwise it is mem[0].
    - Otherwise go to ISSUE with pc=0, instr_out=slot-0 word, instr_valid=1, and issued_count=0.
- ISSUE:
  - Handshake occurs when instr_valid=1 and instr_ready=1. On each handshake, issued_count increments.
  - After a handshake with pc=DEPTH-1, or with mem[pc+1][11:9]=000: go to IDLE, instr_valid=0, pulse done. pc and instr_out hold their last values.
  - After any other handshake: pc<=pc+1, instr_out<=mem[pc+1], instr_valid stays 1 (back-to-back issue, 1 instruction per cycle).
  - With no handshake (instr_ready=0): instr_out, pc and instr_valid are held stable.
  - wr_en and start are ignored.
- abort, from any state: next cycle IDLE, instr_valid=0, done=0. issued_count holds; program store is unchanged. abort has priority over start and over a same-cycle handshake. When an abort coincides with a handshake, the handshake is not counted.
- issued_count never exceeds DEPTH, so AW+1 bits cannot overflow.

## Timing
- Reset (one rising edge with rst=1):
  - State returns to IDLE.
  - instr_out=0, instr_valid=0, busy=0, done=0, pc=0, issued_count=0.
  - All program slots are cleared to 0 (HALT).
- Reset mid-ISSUE aborts with no done pulse. Reset has priority over abort, start and wr_en.
- Latency:
  - start sampled at edge E: instr_valid=1 and the slot-0 word appear after E.
  - A handshake at edge H puts the next instruction on instr_out after H.
  - done is high for exactly the one cycle after the completing edge; busy falls in that same cycle.
- A write issued in IDLE is visible to a start sampled at the next edge. For slot 0 only, a write is also visible to a start sampled at the same edge.
- instr_valid never deasserts without either a handshake, abort or rst.

## Test plan
- Program load and full run:
  - Load slots 0-6 with 0x281, 0x4C1, 0x701, 0x901, 0xBEE, 0xDEE, 0xE88; slot 7=0x000. Hold instr_ready=1 and pulse start at edge 0.
  - Required: instr_out shows the seven words in order after edges 0..6; instr_valid falls and done=1 after edge 7; issued_count=7; pc=6.
- Backpressure:
  - Same program; instr_ready toggles 1,0,0,1,...
  - Required: instr_out and pc stay stable while instr_ready=0; there is no skipped or duplicated word; issued_count=7 at done.
- Empty program and bypass:
  - After reset, start with slot 0=0x000. Required: done pulses the next cycle and instr_valid stays 0.
  - Then in one cycle, wr_en with wr_addr=0 and wr_data=0x281, plus start. Required: 0x281 is issued, followed by done.
- Full store and last-slot boundary:
  - All 16 slots=0x281; instr_ready=1.
  - Required: 16 handshakes, pc reaches 15, done after the 16th handshake, issued_count=16 (0x10).
- Abort and reset mid-run:
  - abort during the 3rd instruction. Required: instr_valid=0 the next cycle, no done, issued_count=2.
  - Repeat with rst instead. Required: all outputs are 0 and a subsequent start immediately returns done (store cleared).
- Ignored inputs while busy:
  - wr_en to slot 3 and start while in ISSUE. Required: slot 3 is unchanged when issued, and the sequence does not restart.
